booth_accumulator: RTL and testbench

BOOTH_ACCUMULATOR -- requirements
Module: booth_accumulator

---
 rtl/booth_accumulator_if.sv | 31 +++
 rtl/booth_accumulator.sv | 76 +++++++
 tb/tb_booth_accumulator.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/booth_accumulator_if.sv
// Handshake bundle between a Booth term encoder, the accumulator and the product consumer.
// master drives term sets and consumes products; slave is the accumulator side.
interface booth_accumulator_if #(
    parameter int unsigned PP_WIDTH  = 64,
    parameter int unsigned NUM_TERMS = 17
);
    logic                          in_valid;
    logic                          in_ready;
    logic [PP_WIDTH*NUM_TERMS-1:0] terms;
    logic                          out_valid;
    logic                          out_ready;
    logic [PP_WIDTH-1:0]           product;

    modport master (
        output in_valid,
        output terms,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product
    );

    modport slave (
        input  in_valid,
        input  terms,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product
    );
endinterface

// File: rtl/booth_accumulator.sv
// Sequential Booth partial-product accumulator: latches a full term set, adds one term per
// cycle, then holds the product until the consumer takes it.
module booth_accumulator #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_TERMS  = DATA_WIDTH / 2 + 1,
    parameter int unsigned PP_WIDTH   = 2 * DATA_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    booth_accumulator_if.slave  bus,
    output logic                busy
);
    localparam int unsigned CntW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_TERMS - 1);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e                        state_q, state_d;
    logic [PP_WIDTH-1:0]           acc_q, acc_d;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic [PP_WIDTH*NUM_TERMS-1:0] terms_q, terms_d;
    logic [PP_WIDTH-1:0]           cur_term;

    assign cur_term = terms_q[32'(cnt_q) * PP_WIDTH +: PP_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            terms_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            terms_q <= terms_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        terms_d = terms_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    terms_d = bus.terms;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                // Carry out of the top bit is dropped: product is modulo 2^PP_WIDTH.
                acc_d = acc_q + cur_term;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.product   = acc_q;
    assign busy          = (state_q != StIdle);
endmodule

// File: tb/tb_booth_accumulator.sv
// Directed bench for booth_accumulator at DATA_WIDTH=8: vector table plus stall, reset-abort
// and back-to-back sequences.
module tb_booth_accumulator;
    localparam int unsigned DW = 8;
    localparam int unsigned NT = 5;
    localparam int unsigned PW = 16;

    typedef struct {
        logic [PW*NT-1:0] terms;
        logic [PW-1:0]    exp;
    } vec_t;

    logic clk;
    logic rst;
    logic busy;
    int   n_vec;
    int   n_err;

    booth_accumulator_if #(.PP_WIDTH(PW), .NUM_TERMS(NT)) bus ();

    booth_accumulator #(
        .DATA_WIDTH(DW),
        .NUM_TERMS (NT),
        .PP_WIDTH  (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [PW*NT-1:0] pack(input logic [PW-1:0] t0, input logic [PW-1:0] t1,
                                              input logic [PW-1:0] t2, input logic [PW-1:0] t3,
                                              input logic [PW-1:0] t4);
        return {t4, t3, t2, t1, t0};
    endfunction

    // One full operation: accept, garbage on terms afterwards, latency/product check, release.
    task automatic run_op(input string name, input logic [PW*NT-1:0] t, input logic [PW-1:0] exp);
        int lat;
        check({name, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.terms    = t;
        tick();
        bus.in_valid = 1'b0;
        bus.terms    = {$urandom, $urandom, $urandom};
        check({name, "_busy"}, 64'(busy), 64'd1);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.out_valid && lat < 20);
        check({name, "_latency"}, 64'(lat), 64'(NT));
        check({name, "_product"}, 64'(bus.product), 64'(exp));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, "_released"}, {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
    endtask

    vec_t             vecs[5];
    logic [PW*NT-1:0] b2b_terms[3];
    logic [PW-1:0]    b2b_exp[3];
    int               acc_cyc[3];
    int               acc_n;
    int               done_n;
    int               ov_seen;
    logic             hs;

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0] = '{pack(16'h000F, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'h000F};
        vecs[1] = '{pack(16'hFFF6, 16'h0014, 16'h0000, 16'h0000, 16'h0000), 16'h000A};
        vecs[2] = '{pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 16'hFFFB};
        vecs[3] = '{pack(16'h1234, 16'h1111, 16'h0001, 16'h0000, 16'h8000), 16'hA346};
        vecs[4] = '{pack(16'h7FFF, 16'h0001, 16'hFFFF, 16'h0002, 16'h0000), 16'h8001};

        b2b_terms[0] = pack(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
        b2b_exp[0]   = 16'h0005;
        b2b_terms[1] = pack(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000);
        b2b_exp[1]   = 16'hF000;
        b2b_terms[2] = pack(16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0003);
        b2b_exp[2]   = 16'h0003;

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.terms     = '1;
        repeat (3) tick();
        check("reset_outputs", {60'd0, bus.in_ready, bus.out_valid, busy, 1'b0}, 64'b1000);
        check("reset_product", 64'(bus.product), 64'd0);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.terms     = '0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].terms, vecs[i].exp);
        end

        // Stall with noise on the input side: nothing moves until out_ready.
        bus.in_valid = 1'b1;
        bus.terms    = vecs[3].terms;
        tick();
        bus.in_valid = 1'b0;
        repeat (NT) tick();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.terms    = {$urandom, $urandom, $urandom};
            tick();
            check($sformatf("stall%0d_state", i), {61'd0, bus.out_valid, bus.in_ready, busy},
                  64'b101);
            check($sformatf("stall%0d_product", i), 64'(bus.product), 64'(vecs[3].exp));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("stall_release", {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
        tick();
        check("stall_no_accept", 64'(busy), 64'd0);

        // Reset sampled on the third ACCUM edge aborts the operation.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.terms     = vecs[2].terms;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state", {61'd0, bus.in_ready, bus.out_valid, busy}, 64'b100);
        check("abort_product", 64'(bus.product), 64'd0);
        ov_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid) ov_seen++;
        end
        check("abort_no_out_valid", 64'(ov_seen), 64'd0);
        bus.out_ready = 1'b0;
        run_op("after_abort", b2b_terms[0], 16'h0005);

        // Back-to-back with in_valid and out_ready held high.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.terms     = b2b_terms[0];
        acc_n         = 0;
        done_n        = 0;
        for (int cyc = 0; cyc < 60 && done_n < 3; cyc++) begin
            if (bus.out_valid && done_n < 3) begin
                check($sformatf("b2b%0d_product", done_n), 64'(bus.product),
                      64'(b2b_exp[done_n]));
                done_n++;
            end
            hs = bus.in_valid && bus.in_ready;
            tick();
            if (hs && acc_n < 3) begin
                acc_cyc[acc_n] = cyc;
                acc_n++;
                if (acc_n < 3) bus.terms = b2b_terms[acc_n];
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_done_count", 64'(done_n), 64'd3);
        check("b2b_accept_count", 64'(acc_n), 64'd3);
        if (acc_n == 3) begin
            check("b2b_spacing01", 64'(acc_cyc[1] - acc_cyc[0]), 64'(NT + 2));
            check("b2b_spacing12", 64'(acc_cyc[2] - acc_cyc[1]), 64'(NT + 2));
        end
        tick();
        check("final_idle", {62'd0, bus.in_ready, busy}, 64'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
